// File: rtl/img_pkg.sv
//==============================================================================
// img_pkg - shared sequencer state encoding, image layout constants, helpers.
// Rev 1.0
//==============================================================================
`default_nettype none

package img_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SYNC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int c_hdr_bytes = 54;
  localparam int c_bpp       = 3;
  localparam int c_cnt_w     = 11;

  localparam logic [c_cnt_w-1:0] c_cnt_max = '1;

  function automatic logic [c_cnt_w-1:0] f_sat_inc(input logic [c_cnt_w-1:0] v);
    return (v == c_cnt_max) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cap_addr_gen.sv
//==============================================================================
// cap_addr_gen - registered byte address of a pixel in a bottom-up BGR image.
// Rev 1.0
//==============================================================================
`default_nettype none

module cap_addr_gen
  import img_pkg::*;
#(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 480,
  parameter int HDR_BYTES = c_hdr_bytes
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [c_cnt_w-1:0] i_line,
  input  logic [c_cnt_w-1:0] i_pix,
  output logic [31:0]        o_addr
);

  localparam logic [31:0] c_last_row  = 32'(V_ACTIVE - 1);
  localparam logic [31:0] c_row_bytes = 32'(H_ACTIVE * c_bpp);
  localparam logic [31:0] c_pix_bytes = 32'(c_bpp);
  localparam logic [31:0] c_hdr       = 32'(HDR_BYTES);

  logic [31:0] w_addr;
  logic [31:0] r_addr;

  // Line 0 is stored last: the image file is written bottom row first.
  always_comb begin
    w_addr = (c_last_row - 32'(i_line)) * c_row_bytes + 32'(i_pix) * c_pix_bytes + c_hdr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= w_addr;
    end
  end

  assign o_addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/frame_seq_ctrl.sv
//==============================================================================
// frame_seq_ctrl - camera capture sequencer: arms sensor, counts frames, writes pixels.
// Rev 1.0
//==============================================================================
`default_nettype none

module frame_seq_ctrl
  import img_pkg::*;
#(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 480,
  parameter bit VS_POL    = 1'b0,
  parameter int HDR_BYTES = c_hdr_bytes
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  frame_num,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  output logic        cam_rst_n,
  output logic        cap_we,
  output logic [31:0] cap_addr,
  output logic [7:0]  frame_cnt,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [c_cnt_w-1:0] c_h = c_cnt_w'(H_ACTIVE);
  localparam logic [c_cnt_w-1:0] c_v = c_cnt_w'(V_ACTIVE);

  state_t             r_state;
  state_t             w_next;
  logic               r_vs_d;
  logic               r_href_d;
  logic               r_stop_pend;
  logic [7:0]         r_fnum;
  logic [7:0]         r_fcnt;
  logic               r_err;
  logic               r_we;
  logic [c_cnt_w-1:0] r_pix;
  logic [c_cnt_w-1:0] r_line;

  logic w_vs_start;
  logic w_href_rise;
  logic w_href_fall;
  logic w_cap_act;
  logic w_in_img;
  logic w_pix_wr;
  logic w_frame_end;
  logic w_last;
  logic w_run;

  assign w_vs_start  = (r_vs_d == ~VS_POL) && (cmos_vsync == VS_POL);
  assign w_href_rise = cmos_href && !r_href_d;
  assign w_href_fall = !cmos_href && r_href_d;
  // The href rising cycle seen in SYNC is already pixel 0 of line 0.
  assign w_cap_act   = (r_state == ST_CAPTURE) || ((r_state == ST_SYNC) && w_href_rise);
  assign w_in_img    = (r_line < c_v);
  assign w_pix_wr    = w_cap_act && cmos_href && w_in_img;
  assign w_frame_end = (r_state == ST_CAPTURE) && w_vs_start;
  assign w_last      = (r_fnum != 8'd0) && ((r_fcnt + 8'd1) == r_fnum);
  assign w_run       = (r_state == ST_ARM) || (r_state == ST_SYNC) || (r_state == ST_CAPTURE);

  always_comb begin
    w_next    = r_state;
    cam_rst_n = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_ARM;
      end
      ST_ARM: begin
        cam_rst_n = 1'b1;
        if (stop)            w_next = ST_DONE;
        else if (w_vs_start) w_next = ST_SYNC;
      end
      ST_SYNC: begin
        cam_rst_n = 1'b1;
        if (stop)             w_next = ST_DONE;
        else if (w_href_rise) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cam_rst_n = 1'b1;
        if (w_frame_end && (w_last || stop || r_stop_pend)) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_vs_d      <= VS_POL;
      r_href_d    <= 1'b0;
      r_stop_pend <= 1'b0;
      r_fnum      <= '0;
      r_fcnt      <= '0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_pix       <= '0;
      r_line      <= '0;
    end else begin
      r_state  <= w_next;
      r_vs_d   <= cmos_vsync;
      r_href_d <= cmos_href;
      r_we     <= w_pix_wr;

      if ((r_state == ST_IDLE) && start) begin
        r_fcnt      <= '0;
        r_err       <= 1'b0;
        r_fnum      <= frame_num;
        r_stop_pend <= 1'b0;
      end

      if (w_run && stop) r_stop_pend <= 1'b1;

      if (r_state == ST_ARM) begin
        r_pix  <= '0;
        r_line <= '0;
      end

      if (w_cap_act) begin
        if (cmos_href) begin
          if (!w_in_img) r_err <= 1'b1;
          r_pix <= f_sat_inc(r_pix);
        end else if (w_href_fall) begin
          if (r_pix != c_h) r_err <= 1'b1;
          r_pix  <= '0;
          r_line <= f_sat_inc(r_line);
        end
        if (w_frame_end) begin
          if (r_line != c_v) r_err <= 1'b1;
          r_fcnt <= r_fcnt + 8'd1;
          r_line <= '0;
        end
      end
    end
  end

  cap_addr_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .HDR_BYTES (HDR_BYTES)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_pix_wr),
    .i_line (r_line),
    .i_pix  (r_pix),
    .o_addr (cap_addr)
  );

  assign cap_we    = r_we;
  assign frame_cnt = r_fcnt;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_frame_seq_ctrl.sv
//==============================================================================
// tb_frame_seq_ctrl - randomized frame runs against a line/pixel level image model.
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_frame_seq_ctrl;

  localparam int c_h   = 8;
  localparam int c_v   = 6;
  localparam int c_hdr = 54;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  fnum = 8'd0;
  logic        vsync = 1'b1;
  logic        href = 1'b0;
  logic        cam_rst_n, cap_we, busy, done, err;
  logic [31:0] cap_addr;
  logic [7:0]  frame_cnt;

  logic        f_start = 1'b0;
  logic        f_vsync = 1'b1;
  logic        f_href = 1'b0;
  logic        f_cam_rst_n, f_we, f_busy, f_done, f_err;
  logic [31:0] f_addr;
  logic [7:0]  f_fcnt;

  frame_seq_ctrl #(
    .H_ACTIVE(c_h), .V_ACTIVE(c_v), .VS_POL(1'b0), .HDR_BYTES(c_hdr)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .frame_num(fnum),
    .cmos_vsync(vsync), .cmos_href(href), .cam_rst_n(cam_rst_n), .cap_we(cap_we),
    .cap_addr(cap_addr), .frame_cnt(frame_cnt), .busy(busy), .done(done), .err(err)
  );

  frame_seq_ctrl u_full (
    .clk(clk), .rst_n(rst_n), .start(f_start), .stop(1'b0), .frame_num(8'd1),
    .cmos_vsync(f_vsync), .cmos_href(f_href), .cam_rst_n(f_cam_rst_n), .cap_we(f_we),
    .cap_addr(f_addr), .frame_cnt(f_fcnt), .busy(f_busy), .done(f_done), .err(f_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_done = 0;
  bit          exp_err = 1'b0;
  logic [31:0] q_got[$];
  logic [31:0] q_exp[$];

  always @(posedge clk) begin
    #1;
    if (cap_we) q_got.push_back(cap_addr);
    if (done) n_done++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int fn);
    @(negedge clk);
    fnum  = 8'(fn);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    vsync = 1'b0;
    tick(2);
    vsync = 1'b1;
    tick(2);
  endtask

  function automatic logic [31:0] img_addr(input int l, input int p);
    return 32'((c_v - 1 - l) * c_h * 3 + p * 3 + c_hdr);
  endfunction

  task automatic send_line(input int len, input int lidx, input bit capt);
    for (int p = 0; p < len; p++) begin
      @(negedge clk);
      href = 1'b1;
      if (capt && lidx < c_v) q_exp.push_back(img_addr(lidx, p));
    end
    @(negedge clk);
    href = 1'b0;
    if (capt && (len != c_h || lidx >= c_v)) exp_err = 1'b1;
    tick($urandom_range(1, 3));
  endtask

  task automatic send_frame(input int nlines, input int bad_idx, input int bad_len);
    for (int l = 0; l < nlines; l++)
      send_line((l == bad_idx) ? bad_len : c_h, l, 1'b1);
    if (nlines != c_v) exp_err = 1'b1;
    tick(1);
  endtask

  task automatic run_check(input string tag, input int fexp, input int done0);
    tick(2);
    check_val({tag, "_fcnt"}, frame_cnt, 32'(fexp % 256));
    check_val({tag, "_err"}, err, 32'(exp_err));
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_camrst"}, cam_rst_n, 0);
    check_val({tag, "_done_pulses"}, 32'(n_done - done0), 1);
    check_val({tag, "_wr_count"}, q_got.size(), q_exp.size());
    for (int i = 0; i < q_got.size() && i < q_exp.size(); i++)
      check_val({tag, "_wr_addr"}, q_got[i], q_exp[i]);
    q_got.delete();
    q_exp.delete();
  endtask

  initial begin
    int d0;
    int nf;
    int kind;

    tick(3);
    check_val("rst_camrst", cam_rst_n, 0);
    check_val("rst_we", cap_we, 0);
    check_val("rst_addr", cap_addr, 0);
    check_val("rst_fcnt", frame_cnt, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    rst_n = 1'b1;
    tick(2);

    // Full-size geometry: first two pixel addresses of a default 800x480 image.
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    tick(2);
    f_vsync = 1'b0;
    @(negedge clk);
    f_href = 1'b1;
    @(negedge clk);
    check_val("full_first_we", f_we, 1);
    check_val("full_first_addr", f_addr, 32'd1149654);
    @(negedge clk);
    f_href = 1'b0;
    check_val("full_second_addr", f_addr, 32'd1149657);

    for (int r = 0; r < 6; r++) begin
      nf = $urandom_range(1, 3);
      exp_err = 1'b0;
      d0 = n_done;
      pulse_start(nf);
      tick(1);
      check_val("arm_busy", busy, 1);
      check_val("arm_camrst", cam_rst_n, 1);
      send_line(c_h, 0, 1'b0);
      for (int f = 0; f < nf; f++) begin
        vs_pulse();
        if (r % 2 == 1 && f == 0) pulse_start($urandom_range(4, 9));
        kind = $urandom_range(0, 4);
        case (kind)
          2:       send_frame(c_v, $urandom_range(0, c_v - 1), c_h - 1);
          3:       send_frame(c_v + 1, -1, c_h);
          4:       send_frame(c_v, $urandom_range(0, c_v - 1), c_h + 1);
          default: send_frame(c_v, -1, c_h);
        endcase
      end
      vs_pulse();
      run_check("rand_run", nf, d0);
    end

    // Continuous run stopped during frame 3.
    exp_err = 1'b0;
    d0 = n_done;
    pulse_start(0);
    tick(2);
    for (int f = 0; f < 3; f++) begin
      vs_pulse();
      if (f == 2) begin
        send_line(c_h, 0, 1'b1);
        send_line(c_h, 1, 1'b1);
        pulse_stop();
        for (int l = 2; l < c_v; l++) send_line(c_h, l, 1'b1);
      end else begin
        send_frame(c_v, -1, c_h);
      end
    end
    vs_pulse();
    run_check("cont_stop", 3, d0);

    // Stop while armed ends the run at once.
    d0 = n_done;
    pulse_start(2);
    tick(1);
    pulse_stop();
    tick(2);
    check_val("arm_stop_done", 32'(n_done - d0), 1);
    check_val("arm_stop_fcnt", frame_cnt, 0);
    check_val("arm_stop_busy", busy, 0);
    check_val("arm_stop_wr", q_got.size(), 0);

    // Start and stop in the same idle cycle: stop must not shorten the run.
    exp_err = 1'b0;
    d0 = n_done;
    @(negedge clk);
    fnum = 8'd2;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    tick(1);
    for (int f = 0; f < 2; f++) begin
      vs_pulse();
      send_frame(c_v, -1, c_h);
    end
    vs_pulse();
    run_check("start_stop", 2, d0);

    // Reset in the middle of the second frame.
    exp_err = 1'b0;
    pulse_start(2);
    tick(1);
    vs_pulse();
    send_frame(c_v, -1, c_h);
    vs_pulse();
    send_line(c_h, 0, 1'b1);
    @(negedge clk);
    href = 1'b1;
    tick(2);
    check_val("pre_rst_fcnt", frame_cnt, 1);
    d0 = n_done;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid_rst_we", cap_we, 0);
    check_val("mid_rst_addr", cap_addr, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_camrst", cam_rst_n, 0);
    check_val("mid_rst_fcnt", frame_cnt, 0);
    check_val("mid_rst_err", err, 0);
    @(negedge clk);
    href = 1'b0;
    tick(3);
    check_val("mid_rst_no_done", 32'(n_done - d0), 0);
    rst_n = 1'b1;
    q_got.delete();
    q_exp.delete();
    tick(2);
    exp_err = 1'b0;
    d0 = n_done;
    pulse_start(1);
    tick(1);
    vs_pulse();
    send_frame(c_v, -1, c_h);
    vs_pulse();
    run_check("post_rst", 1, d0);

    // Continuous run long enough to wrap the frame counter.
    exp_err = 1'b0;
    d0 = n_done;
    pulse_start(0);
    tick(1);
    vs_pulse();
    send_frame(c_v, -1, c_h);
    for (int f = 0; f < 256; f++) begin
      vs_pulse();
      send_frame(0, -1, c_h);
    end
    pulse_stop();
    vs_pulse();
    run_check("wrap", 257, d0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_seq_ctrl.md
FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have parameter VS_POL, default 0, vsync level during sync pulse.
REQ-004 SHALL have parameter HDR_BYTES, default 54, image header offset in bytes.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to run a capture sequence.
REQ-008 stop  input  1  one-cycle request to end a continuous run at the next frame boundary.
REQ-009 frame_num  input  8  frames to capture; 0 means continuous until stop.
REQ-010 cmos_vsync  input  1  frame sync from the camera timing source.
REQ-011 cmos_href  input  1  line-valid from the camera timing source.
REQ-012 cam_rst_n  output  1  holds the camera timing source in reset while low.
REQ-013 cap_we  output  1  pixel write strobe.
REQ-014 cap_addr  output  32  byte address of the current pixel in the bottom-up, 3-byte/pixel image.
REQ-015 frame_cnt  output  8  completed frames in the current run.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse when the run ends.
REQ-018 err  output  1  sticky geometry error flag.

Function
REQ-019 SHALL implement FSM states IDLE, ARM, SYNC, CAPTURE, DONE.
REQ-020 IDLE: start=1 -> ARM, clear frame_cnt and err, latch frame_num; start in any other state ignored.
REQ-021 ARM: cam_rst_n=1 from the first ARM cycle onward; wait for vs_start, defined as cmos_vsync changing from ~VS_POL to VS_POL between consecutive cycles, then -> SYNC.
REQ-022 SYNC: wait for the first cmos_href rising edge -> CAPTURE; pixel and line counters zeroed on entry.
REQ-023 CAPTURE: each cycle with cmos_href=1 -> cap_we=1 next cycle; cap_addr=(V_ACTIVE-1-line)*H_ACTIVE*3+pix*3+HDR_BYTES, registered with the same 1-cycle latency; pix increments per href cycle.
REQ-024 Falling edge of cmos_href: if pix != H_ACTIVE then err=1; pix cleared; line incremented.
REQ-025 vs_start in CAPTURE ends a frame: if line != V_ACTIVE then err=1; frame_cnt+1; line cleared.
REQ-026 After frame end: -> DONE if latched frame_num!=0 and frame_cnt+1==frame_num, or if stop is pending; otherwise stay in CAPTURE.
REQ-027 stop in any state other than IDLE/DONE SHALL set a pending flag, acted on only at the next frame end; stop in ARM/SYNC -> DONE immediately with frame_cnt unchanged.
REQ-028 DONE: done=1 for exactly one cycle, cam_rst_n=0, -> IDLE; busy=0 in IDLE only.
REQ-029 cmos_href high with line==V_ACTIVE SHALL set err and suppress cap_we (no write beyond image).
REQ-030 pix and line SHALL saturate at 2047 (11 bits); address arithmetic SHALL use 32-bit unsigned.
REQ-031 frame_cnt SHALL wrap from 255 to 0 in continuous mode.
REQ-032 start and stop in the same IDLE cycle: start accepted, stop ignored.

Reset
REQ-033 rst_n low SHALL force state IDLE, cam_rst_n=0, cap_we=0, cap_addr=0, frame_cnt=0, busy=0, done=0, err=0, stop pending=0, edge-detect registers to VS_POL / 0; effective mid-frame with no done pulse.

Structure
REQ-034 FSM state enum, HDR_BYTES and bytes-per-pixel constant SHALL live in shared package img_pkg.
REQ-035 Address generation SHALL be a sub-module cap_addr_gen (line, pix in; registered cap_addr out).

Verification
REQ-036 start, frame_num=1, nominal 800x480 timing -> one done pulse after the second vs_start, frame_cnt=1, err=0, 384000 cap_we pulses.
REQ-037 First pixel of frame -> cap_addr=479*2400+54=1149654; last pixel -> cap_addr=2451.
REQ-038 Line with 799 href cycles injected -> err=1 and remains set until next start.
REQ-039 frame_num=0, stop during frame 3 -> done at end of frame 3, frame_cnt=3.
REQ-040 rst_n low mid-CAPTURE -> all outputs at reset values within one cycle, no done pulse; next start runs normally.
REQ-041 start asserted while busy -> ignored, frame_cnt sequence unaffected.
